// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and stage-register layouts for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        PC_SEL_SEQ = 2'b00,
        PC_SEL_BR  = 2'b01,
        PC_SEL_JMP = 2'b10
    } pc_sel_e;

    // An all-zero value of any stage register is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch_eq;
        logic [2:0] alu_c;
        logic       alu_src;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } idex_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [4:0] dst;
    } exmem_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] dst;
    } memwb_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand source select for one EX operand; the younger producer in MEM wins over WB.
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dst,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_dst,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_dst != 5'd0) && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_dst != 5'd0) && (wb_dst == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Control pipeline for the 5-stage CPU: stage control registers, load-use stall,
// branch/jump flush, EX forwarding selects and saturating event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_branch_eq,
    input  logic             id_jump,
    input  logic             id_alu_src,
    input  logic             id_rd_sel,
    input  logic [2:0]       id_alu_c,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [1:0]       pc_sel,
    output logic [2:0]       ex_alu_c,
    output logic             ex_alu_src,
    output logic             mem_mem_write,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [4:0]       wb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    idex_t  ex_q;
    idex_t  ex_d;
    exmem_t mem_q;
    memwb_t wb_q;

    logic id_uses_rt;
    logic luh;
    logic bt;
    logic jmp;
    logic stall_inc;
    logic flush_inc;

    assign id_uses_rt = ~id_alu_src | id_mem_write;
    assign luh = ex_q.mem_to_reg && (ex_q.dst != 5'd0) &&
                 ((ex_q.dst == id_rs) || (id_uses_rt && (ex_q.dst == id_rt)));
    assign bt  = ex_q.branch_eq & ex_zero;
    // The jump input is live even while reset is held, so mask it to keep pc_sel at PC+4.
    assign jmp = id_jump & ~rst;

    assign stall_inc = ~bt & luh;
    assign flush_inc = bt | (~luh & jmp);

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        pc_sel     = PC_SEL_SEQ;
        if (bt) begin
            pc_sel     = PC_SEL_BR;
            ifid_flush = 1'b1;
        end else if (luh) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (jmp) begin
            pc_sel     = PC_SEL_JMP;
            ifid_flush = 1'b1;
        end
    end

    // Any redirect or stall turns the ID instruction into a bubble; a jump never needs EX.
    always_comb begin
        ex_d = '0;
        if (!(bt || luh || jmp)) begin
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            ex_d.mem_write  = id_mem_write;
            ex_d.branch_eq  = id_branch_eq;
            ex_d.alu_c      = id_alu_c;
            ex_d.alu_src    = id_alu_src;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.dst        = id_rd_sel ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ex_q            <= ex_d;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.mem_write <= ex_q.mem_write;
            mem_q.dst       <= ex_q.dst;
            wb_q.reg_write  <= mem_q.reg_write;
            wb_q.mem_to_reg <= mem_q.mem_to_reg;
            wb_q.dst        <= mem_q.dst;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign ex_alu_c      = ex_q.alu_c;
    assign ex_alu_src    = ex_q.alu_src;
    assign mem_mem_write = mem_q.mem_write;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_dst        = wb_q.dst;

    pipe_fwd_sel u_fwd_a (
        .src           (ex_q.rs),
        .mem_reg_write (mem_q.reg_write),
        .mem_dst       (mem_q.dst),
        .wb_reg_write  (wb_q.reg_write),
        .wb_dst        (wb_q.dst),
        .sel           (fwd_a)
    );

    pipe_fwd_sel u_fwd_b (
        .src           (ex_q.rt),
        .mem_reg_write (mem_q.reg_write),
        .mem_dst       (mem_q.dst),
        .wb_reg_write  (wb_q.reg_write),
        .wb_dst        (wb_q.dst),
        .sel           (fwd_b)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed program snippets plus random instruction streams,
// compared every cycle against an instruction-level model of the pipeline.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_reg_write, id_mem_to_reg, id_mem_write, id_branch_eq;
    logic          id_jump, id_alu_src, id_rd_sel;
    logic [2:0]    id_alu_c;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          ex_zero;
    logic          pc_en, ifid_en, ifid_flush;
    logic [1:0]    pc_sel;
    logic [2:0]    ex_alu_c;
    logic          ex_alu_src, mem_mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0]    wb_dst;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit rw;
        bit m2r;
        bit mw;
        bit beq;
        int aluc;
        bit asrc;
        int rs;
        int rt;
        int dst;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    int    m_stall, m_flush;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_branch_eq(id_branch_eq), .id_jump(id_jump), .id_alu_src(id_alu_src), .id_rd_sel(id_rd_sel),
        .id_alu_c(id_alu_c), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .pc_sel(pc_sel),
        .ex_alu_c(ex_alu_c), .ex_alu_src(ex_alu_src), .mem_mem_write(mem_mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic slot_t emptySlot();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic slot_t idSlot();
        slot_t s;
        s.rw   = id_reg_write;
        s.m2r  = id_mem_to_reg;
        s.mw   = id_mem_write;
        s.beq  = id_branch_eq;
        s.aluc = int'(id_alu_c);
        s.asrc = id_alu_src;
        s.rs   = int'(id_rs);
        s.rt   = int'(id_rt);
        s.dst  = id_rd_sel ? int'(id_rd) : int'(id_rt);
        return s;
    endfunction

    // Where an EX operand register should come from: newest writer in flight, never $0.
    function automatic int srcOf(int r);
        if (r != 0 && m_mem.rw && m_mem.dst == r) return 2;
        if (r != 0 && m_wb.rw && m_wb.dst == r) return 1;
        return 0;
    endfunction

    task automatic hazards(output bit bt, output bit luh, output bit jmp);
        bit uses_rt;
        uses_rt = !id_alu_src || id_mem_write;
        bt  = m_ex.beq && ex_zero;
        luh = m_ex.m2r && m_ex.dst != 0 &&
              (m_ex.dst == int'(id_rs) || (uses_rt && m_ex.dst == int'(id_rt)));
        jmp = id_jump && !rst;
    endtask

    task automatic modelClear();
        m_ex    = emptySlot();
        m_mem   = emptySlot();
        m_wb    = emptySlot();
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic chk(string tag, string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        bit bt, luh, jmp;
        int exp_sel;
        hazards(bt, luh, jmp);
        exp_sel = bt ? 1 : (luh ? 0 : (jmp ? 2 : 0));
        chk(tag, "pc_en",      pc_en,      !(!bt && luh));
        chk(tag, "ifid_en",    ifid_en,    !(!bt && luh));
        chk(tag, "ifid_flush", ifid_flush, bt || (!luh && jmp));
        chk(tag, "pc_sel",     pc_sel,     exp_sel);
        chk(tag, "ex_alu_c",   ex_alu_c,   m_ex.aluc);
        chk(tag, "ex_alu_src", ex_alu_src, m_ex.asrc);
        chk(tag, "mem_mem_write", mem_mem_write, m_mem.mw);
        chk(tag, "wb_reg_write",  wb_reg_write,  m_wb.rw);
        chk(tag, "wb_mem_to_reg", wb_mem_to_reg, m_wb.m2r);
        chk(tag, "wb_dst",     wb_dst,     m_wb.dst);
        chk(tag, "fwd_a",      fwd_a,      srcOf(m_ex.rs));
        chk(tag, "fwd_b",      fwd_b,      srcOf(m_ex.rt));
        chk(tag, "stall_cnt",  stall_cnt,  m_stall);
        chk(tag, "flush_cnt",  flush_cnt,  m_flush);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic tick();
        bit bt, luh, jmp;
        slot_t issue;
        int ns, nf;
        hazards(bt, luh, jmp);
        issue = (bt || luh || jmp) ? emptySlot() : idSlot();
        ns = (!bt && luh && m_stall < CMAX) ? m_stall + 1 : m_stall;
        nf = ((bt || (!luh && jmp)) && m_flush < CMAX) ? m_flush + 1 : m_flush;
        @(posedge clk);
        if (!rst) begin
            m_wb    = m_mem;
            m_mem   = m_ex;
            m_ex    = issue;
            m_stall = ns;
            m_flush = nf;
        end
        @(negedge clk);
    endtask

    task automatic step(string tag);
        #1;
        checkOutput(tag);
        tick();
    endtask

    task automatic applyStimulus(bit rw, bit m2r, bit mw, bit beq, bit j, bit asrc, bit rdsel,
                                 logic [2:0] aluc, int rs, int rt, int rd);
        id_reg_write  = rw;
        id_mem_to_reg = m2r;
        id_mem_write  = mw;
        id_branch_eq  = beq;
        id_jump       = j;
        id_alu_src    = asrc;
        id_rd_sel     = rdsel;
        id_alu_c      = aluc;
        id_rs         = 5'(rs);
        id_rt         = 5'(rt);
        id_rd         = 5'(rd);
    endtask

    task automatic opNop();                    applyStimulus(0,0,0,0,0,0,0, 3'd0,    0, 0, 0);  endtask
    task automatic opR(int rd, int rs, int rt); applyStimulus(1,0,0,0,0,0,1, ALU_ADD, rs, rt, rd); endtask
    task automatic opLw(int rt, int rs);        applyStimulus(1,1,0,0,0,1,0, ALU_ADD, rs, rt, 0);  endtask
    task automatic opSw(int rt, int rs);        applyStimulus(0,0,1,0,0,1,0, ALU_ADD, rs, rt, 0);  endtask
    task automatic opAddi(int rt, int rs);      applyStimulus(1,0,0,0,0,1,0, ALU_ADD, rs, rt, 0);  endtask
    task automatic opBeq(int rs, int rt);       applyStimulus(0,0,0,1,0,0,0, ALU_SUB, rs, rt, 0);  endtask
    task automatic opJ();                       applyStimulus(0,0,0,0,1,0,0, 3'd0,    0, 0, 0);  endtask

    task automatic opRandom();
        int k, a, b, c;
        k = $urandom_range(0, 5);
        a = $urandom_range(0, 3);
        b = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        case (k)
            0: opR(a, b, c);
            1: opLw(a, b);
            2: opSw(a, b);
            3: opAddi(a, b);
            4: opBeq(a, b);
            default: opJ();
        endcase
    endtask

    task automatic doReset(string tag);
        opNop();
        ex_zero = 1'b0;
        rst = 1'b1;
        #1;
        modelClear();
        checkOutput(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit bt, luh, jmp, hold, flushed;
        modelClear();
        opNop();
        ex_zero = 1'b0;
        @(negedge clk);
        doReset("reset");

        // Back-to-back ALU dependency resolves through the MEM path.
        doReset("t1rst");
        opR(3, 1, 2); step("t1a");
        opR(4, 3, 3); step("t1b");
        opNop(); #1; checkOutput("t1c");
        chk("t1", "fwd_a", fwd_a, 2);
        chk("t1", "fwd_b", fwd_b, 2);
        chk("t1", "stall_cnt", stall_cnt, 0);
        tick();

        // Load-use: one stall, then the WB path.
        doReset("t2rst");
        opLw(5, 0); step("t2a");
        opR(6, 5, 1); #1; checkOutput("t2b");
        chk("t2", "pc_en", pc_en, 0);
        chk("t2", "ifid_en", ifid_en, 0);
        tick();
        #1; checkOutput("t2c");
        chk("t2", "pc_en_after", pc_en, 1);
        chk("t2", "ex_bubble", ex_alu_c, 0);
        tick();
        opNop(); #1; checkOutput("t2d");
        chk("t2", "fwd_a", fwd_a, 1);
        chk("t2", "stall_cnt", stall_cnt, 1);
        tick();

        // Taken branch squashes the younger instructions.
        doReset("t3rst");
        opBeq(1, 2); step("t3a");
        opR(7, 1, 2); ex_zero = 1'b1; #1; checkOutput("t3b");
        chk("t3", "pc_sel", pc_sel, 1);
        chk("t3", "ifid_flush", ifid_flush, 1);
        tick();
        ex_zero = 1'b0; opNop();
        for (int i = 0; i < 3; i++) begin
            #1; checkOutput("t3c");
            chk("t3", "wb_reg_write", wb_reg_write, 0);
            tick();
        end
        chk("t3", "flush_cnt", flush_cnt, 1);

        // Not-taken branch lets the next instruction retire.
        doReset("t3nrst");
        opBeq(1, 2); step("t3n_a");
        opR(7, 1, 2); ex_zero = 1'b0; #1; checkOutput("t3n_b");
        chk("t3n", "pc_sel", pc_sel, 0);
        tick();
        opNop(); step("t3n_c"); step("t3n_d");
        #1; checkOutput("t3n_e");
        chk("t3n", "wb_reg_write", wb_reg_write, 1);
        chk("t3n", "wb_dst", wb_dst, 7);
        chk("t3n", "flush_cnt", flush_cnt, 0);

        // Branch in EX beats jump in ID; a single flush is counted.
        doReset("t4rst");
        opBeq(2, 2); step("t4a");
        opJ(); ex_zero = 1'b1; #1; checkOutput("t4b");
        chk("t4", "pc_sel", pc_sel, 1);
        tick();
        ex_zero = 1'b0; opNop(); #1; checkOutput("t4c");
        chk("t4", "flush_cnt", flush_cnt, 1);
        chk("t4", "pc_sel_after", pc_sel, 0);
        tick();

        // No forwarding from $0.
        doReset("t5rst");
        opAddi(0, 0); step("t5a");
        opR(1, 0, 0); step("t5b");
        opNop(); #1; checkOutput("t5c");
        chk("t5", "fwd_a", fwd_a, 0);
        tick();

        // Reset with stores/loads in flight kills every write enable at once.
        doReset("t6rst0");
        opLw(5, 0); step("t6a");
        opSw(6, 0); step("t6b");
        opR(7, 1, 2); step("t6c");
        opJ(); rst = 1'b1; #1;
        modelClear();
        checkOutput("t6rst");
        chk("t6", "mem_mem_write", mem_mem_write, 0);
        chk("t6", "wb_reg_write", wb_reg_write, 0);
        chk("t6", "pc_sel", pc_sel, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        opNop();
        for (int i = 0; i < 3; i++) begin
            #1; checkOutput("t6d");
            chk("t6", "wb_after", wb_reg_write, 0);
            chk("t6", "mw_after", mem_mem_write, 0);
            tick();
        end

        // Counters stop at all-ones.
        doReset("satrst");
        for (int i = 0; i < CMAX + 5; i++) begin
            opLw(1, 0); step("sat_lw");
            opR(2, 1, 0); step("sat_use");
            step("sat_held");
            opJ(); step("sat_j");
            opNop(); step("sat_nop");
        end
        #1; checkOutput("sat");
        chk("sat", "stall_cnt", stall_cnt, CMAX);
        chk("sat", "flush_cnt", flush_cnt, CMAX);
        tick();

        // Random stream; a stalled instruction is re-presented and a flushed slot becomes a nop.
        doReset("rndrst");
        hold = 0;
        flushed = 0;
        for (int i = 0; i < 400; i++) begin
            if (flushed) opNop();
            else if (!hold) opRandom();
            ex_zero = 1'($urandom_range(0, 1));
            hazards(bt, luh, jmp);
            hold    = !bt && luh;
            flushed = bt || (!luh && jmp);
            step("rnd");
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
